wb_unit_gen: RTL and testbench

- Parametrised writeback stage for the LoongArch pipeline. Sits between the MEM stage and the register file, CSR unit, ID forwarding network and debug trace.
- Generalises the single-cycle writeback in three ways:
  - waits multi-cycle for returning load data, then byte/half extracts and sign-extends it;
  - priority-encodes an N-wide exception vector into ecode/esubcode;
  - reports a "pending load" flag to ID so the interlock can stall instead of forwarding stale data.

---
 rtl/wb_pkg.sv | 45 ++++
 rtl/wb_load_align.sv | 30 +++
 rtl/wb_unit_gen.sv | 135 +++++++++++++
 tb/tb_wb_unit_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-op encoding, FSM states,
// the exception ecode table and its priority encoder.
package wb_pkg;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_BU   = 3'd2;
  localparam logic [2:0] LD_H    = 3'd3;
  localparam logic [2:0] LD_HU   = 3'd4;
  localparam logic [2:0] LD_W    = 3'd5;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_WAIT_LD = 2'd1,
    S_COMMIT  = 2'd2
  } wb_state_e;

  // Every architected exception routed here has esubcode 0.
  localparam logic [8:0] ESUBCODE_DEF = 9'h000;

  // Index of the lowest set bit (bit 0 is highest priority); 0 when none set.
  function automatic logic [2:0] excp_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  // Vector bit -> ecode. Slots 5..7 are unassigned and map to 0.
  function automatic logic [5:0] ecode_of(input logic [2:0] idx);
    logic [5:0] ec;
    case (idx)
      3'd0:    ec = 6'h08; // ADEF
      3'd1:    ec = 6'h0D; // INE
      3'd2:    ec = 6'h0B; // SYS
      3'd3:    ec = 6'h0C; // BRK
      3'd4:    ec = 6'h09; // ALE
      default: ec = 6'h00;
    endcase
    return ec;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load data extraction: picks the byte/half addressed by the
// low address bits and sign- or zero-extends it to DATA_W.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ld_op,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension by op type.
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = rdata[{offset[1], 4'b0000} +: 16];
    case (ld_op)
      LD_B:    data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   data = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   data = {{(DATA_W-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_unit_gen.sv
// Writeback stage: waits for load data, extracts/extends it, commits GR
// writes, priority-encodes exceptions and drives forwarding/debug outputs.
// Optional: define WB_RETIRE_CNT_EN to add a 64-bit retire counter port.
module wb_unit_gen
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_EXC = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              me_valid,
  output logic              wb_allowin,
  input  logic [DATA_W-1:0] me_pc,
  input  logic              me_gr_we,
  input  logic [REG_AW-1:0] me_dest,
  input  logic [DATA_W-1:0] me_result,
  input  logic [2:0]        me_ld_op,
  input  logic [NUM_EXC-1:0] me_excp,
  input  logic              me_ertn,
  input  logic              rdata_valid,
  input  logic [DATA_W-1:0] rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_pending,
  output logic              excp_flush,
  output logic              ertn_flush,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [DATA_W-1:0] wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [REG_AW-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt
`endif
);

  wb_state_e          state;
  logic [DATA_W-1:0]  pc_r;
  logic               gr_we_r;
  logic [REG_AW-1:0]  dest_r;
  logic [DATA_W-1:0]  result_r;
  logic [2:0]         ld_op_r;
  logic [NUM_EXC-1:0] excp_r;
  logic               ertn_r;

  logic              commit;
  logic              no_exc;
  logic              accept;
  logic [7:0]        excp8;
  logic [DATA_W-1:0] ld_data;

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .ld_op  (ld_op_r),
    .offset (result_r[1:0]),
    .rdata  (rdata),
    .data   (ld_data)
  );

  assign commit = (state == S_COMMIT);
  assign no_exc = ~|excp_r;
  assign excp8  = 8'(excp_r);

  assign excp_flush  = commit & ~no_exc;
  assign ertn_flush  = commit & ertn_r & no_exc;
  // A flush kills upstream on the same edge, so nothing is accepted then.
  assign wb_allowin  = (state == S_EMPTY) | (commit & ~excp_flush & ~ertn_flush);
  assign accept      = me_valid & wb_allowin;

  assign rf_we       = commit & gr_we_r & no_exc;
  assign rf_waddr    = commit ? dest_r   : '0;
  assign rf_wdata    = commit ? result_r : '0;
  assign wb_pc       = commit ? pc_r     : '0;
  assign wb_ecode    = excp_flush ? ecode_of(excp_idx(excp8)) : 6'h00;
  assign wb_esubcode = excp_flush ? ESUBCODE_DEF : 9'h000;

  // WAIT_LD implies no exception, so only gr_we and the state gate the dest.
  assign fwd_dest    = ((state != S_EMPTY) & gr_we_r & no_exc) ? dest_r : '0;
  assign fwd_data    = result_r;
  assign fwd_pending = (state == S_WAIT_LD);

  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // FSM plus instruction latch; a load's result register is overwritten by
  // the extracted data when it returns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_EMPTY;
      pc_r     <= '0;
      gr_we_r  <= 1'b0;
      dest_r   <= '0;
      result_r <= '0;
      ld_op_r  <= LD_NONE;
      excp_r   <= '0;
      ertn_r   <= 1'b0;
    end else if (accept) begin
      pc_r     <= me_pc;
      gr_we_r  <= me_gr_we;
      dest_r   <= me_dest;
      result_r <= me_result;
      ld_op_r  <= me_ld_op;
      excp_r   <= me_excp;
      ertn_r   <= me_ertn;
      state    <= ((me_ld_op != LD_NONE) && (me_excp == '0)) ? S_WAIT_LD : S_COMMIT;
    end else begin
      case (state)
        S_WAIT_LD: begin
          if (rdata_valid) begin
            result_r <= ld_data;
            state    <= S_COMMIT;
          end
        end
        S_COMMIT: state <= S_EMPTY;
        default:  state <= S_EMPTY;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Counts exception-free commits (ertn included); wraps naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              retire_cnt <= '0;
    else if (commit & no_exc) retire_cnt <= retire_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_unit_gen.sv
// Directed bench for wb_unit_gen: table of single-instruction vectors plus
// hand sequences for stray strobes, back-to-back commit and reset mid-load.
module tb_wb_unit_gen;

  logic        clk = 1'b0;
  logic        resetn;
  logic        me_valid;
  logic        wb_allowin;
  logic [31:0] me_pc;
  logic        me_gr_we;
  logic [4:0]  me_dest;
  logic [31:0] me_result;
  logic [2:0]  me_ld_op;
  logic [4:0]  me_excp;
  logic        me_ertn;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        fwd_pending;
  logic        excp_flush;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  wb_unit_gen dut (
    .clk(clk), .resetn(resetn), .me_valid(me_valid), .wb_allowin(wb_allowin),
    .me_pc(me_pc), .me_gr_we(me_gr_we), .me_dest(me_dest), .me_result(me_result),
    .me_ld_op(me_ld_op), .me_excp(me_excp), .me_ertn(me_ertn),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  ld_op;
    logic [4:0]  excp;
    logic        gr_we;
    logic        ertn;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] rdata;
    int          delay;     // cycles WAIT_LD is held (rdata_valid on the last)
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        exp_xf;
    logic        exp_ef;
    logic [5:0]  exp_ecode;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input vec_t v);
    me_valid  = 1'b1;
    me_pc     = pc;
    me_gr_we  = v.gr_we;
    me_dest   = v.dest;
    me_result = v.result;
    me_ld_op  = v.ld_op;
    me_excp   = v.excp;
    me_ertn   = v.ertn;
  endtask

  initial begin
    // ld_op excp gr_we ertn dest result rdata delay | we wdata xf ef ecode
    vecs[0]  = '{3'd0, 5'b00000, 1'b1, 1'b0, 5'd4,  32'h12345678, 32'h0,        0, 1'b1, 32'h12345678, 1'b0, 1'b0, 6'h00};
    vecs[1]  = '{3'd1, 5'b00000, 1'b1, 1'b0, 5'd5,  32'h00001003, 32'h80FFFF00, 4, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 6'h00};
    vecs[2]  = '{3'd4, 5'b00000, 1'b1, 1'b0, 5'd6,  32'h00002002, 32'hBEEF1234, 2, 1'b1, 32'h0000BEEF, 1'b0, 1'b0, 6'h00};
    vecs[3]  = '{3'd3, 5'b00000, 1'b1, 1'b0, 5'd7,  32'h00002002, 32'hBEEF1234, 3, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0, 6'h00};
    vecs[4]  = '{3'd2, 5'b00000, 1'b1, 1'b0, 5'd8,  32'h00001001, 32'h80FFFF00, 1, 1'b1, 32'h000000FF, 1'b0, 1'b0, 6'h00};
    vecs[5]  = '{3'd5, 5'b00000, 1'b1, 1'b0, 5'd9,  32'h00001000, 32'hCAFEF00D, 2, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 6'h00};
    vecs[6]  = '{3'd3, 5'b00000, 1'b1, 1'b0, 5'd10, 32'h00003000, 32'h00018001, 1, 1'b1, 32'hFFFF8001, 1'b0, 1'b0, 6'h00};
    vecs[7]  = '{3'd0, 5'b00110, 1'b1, 1'b0, 5'd11, 32'h0000AAAA, 32'h0,        0, 1'b0, 32'h0,        1'b1, 1'b0, 6'h0D};
    vecs[8]  = '{3'd0, 5'b00000, 1'b0, 1'b1, 5'd0,  32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b0, 1'b1, 6'h00};
    vecs[9]  = '{3'd0, 5'b11111, 1'b1, 1'b1, 5'd12, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b1, 1'b0, 6'h08};
    vecs[10] = '{3'd1, 5'b10000, 1'b1, 1'b0, 5'd13, 32'h00001001, 32'h0,        0, 1'b0, 32'h0,        1'b1, 1'b0, 6'h09};
    vecs[11] = '{3'd0, 5'b01000, 1'b0, 1'b0, 5'd0,  32'h00000055, 32'h0,        0, 1'b0, 32'h0,        1'b1, 1'b0, 6'h0C};

    resetn = 1'b0; me_valid = 1'b0; me_pc = '0; me_gr_we = 1'b0; me_dest = '0;
    me_result = '0; me_ld_op = '0; me_excp = '0; me_ertn = 1'b0;
    rdata_valid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {rf_we, rf_waddr, rf_wdata, fwd_dest, fwd_pending, excp_flush, ertn_flush, wb_ecode}, 64'h0);
    chk("reset_pc_fwd", {wb_pc, fwd_data}, 64'h0);
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_allowin", wb_allowin, 1'b1);
    step();

    // ---- table-driven single instructions ----
    for (int i = 0; i < 12; i++) begin
      logic [31:0] pc;
      pc = 32'h1C00_0000 + 32'(i * 4);
      drive_instr(pc, vecs[i]);
      step();
      me_valid = 1'b0;
      if (vecs[i].ld_op != 3'd0 && vecs[i].excp == 5'b0) begin
        for (int k = 0; k < vecs[i].delay; k++) begin
          if (k == vecs[i].delay - 1) begin
            rdata_valid = 1'b1;
            rdata = vecs[i].rdata;
          end
          @(negedge clk);
          chk($sformatf("v%0d_pending", i), {fwd_pending, wb_allowin, rf_we}, {1'b1, 1'b0, 1'b0});
          chk($sformatf("v%0d_fwd_dest", i), fwd_dest, vecs[i].dest);
          step();
          rdata_valid = 1'b0;
        end
      end
      @(negedge clk);
      chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("v%0d_waddr", i), rf_waddr, vecs[i].dest);
        chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
        chk($sformatf("v%0d_fwd", i), {fwd_dest, fwd_data}, {vecs[i].dest, vecs[i].exp_wdata});
        chk($sformatf("v%0d_debug", i), {debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata},
            {4'hF, vecs[i].dest, vecs[i].exp_wdata});
      end
      chk($sformatf("v%0d_flush", i), {excp_flush, ertn_flush}, {vecs[i].exp_xf, vecs[i].exp_ef});
      chk($sformatf("v%0d_ecode", i), {wb_ecode, wb_esubcode}, {vecs[i].exp_ecode, 9'h0});
      chk($sformatf("v%0d_allowin", i), wb_allowin, !(vecs[i].exp_xf || vecs[i].exp_ef));
      chk($sformatf("v%0d_pc", i), wb_pc, pc);
      chk($sformatf("v%0d_npend", i), fwd_pending, 1'b0);
      step();
      @(negedge clk);
      chk($sformatf("v%0d_empty", i), {rf_we, excp_flush, ertn_flush, wb_allowin}, {3'b000, 1'b1});
      step();
    end

    // ---- ALE load with stray rdata_valid in COMMIT and EMPTY ----
    drive_instr(32'h1C00_0100, vecs[10]);
    step();
    me_valid = 1'b0;
    rdata_valid = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("ale_commit", {excp_flush, wb_ecode, rf_we, fwd_pending}, {1'b1, 6'h09, 1'b0, 1'b0});
    step();
    @(negedge clk);
    chk("stray_empty", {rf_we, fwd_pending, wb_allowin}, {1'b0, 1'b0, 1'b1});
    step();
    rdata_valid = 1'b0;
    @(negedge clk);
    chk("stray_after", {rf_we, fwd_pending, excp_flush}, 3'b000);

    // ---- back-to-back accept while in COMMIT ----
    step();
    drive_instr(32'h1C00_0200, vecs[0]);
    me_dest = 5'd10; me_result = 32'h0000_0011;
    step();
    me_dest = 5'd11; me_result = 32'h0000_0022; me_pc = 32'h1C00_0204;
    @(negedge clk);
    chk("b2b_first", {rf_we, rf_waddr, rf_wdata, wb_allowin}, {1'b1, 5'd10, 32'h11, 1'b1});
    step();
    me_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second", {rf_we, rf_waddr, rf_wdata, wb_pc}, {1'b1, 5'd11, 32'h22, 32'h1C00_0204});
    step();
    @(negedge clk);
    chk("b2b_empty", rf_we, 1'b0);

    // ---- reset while waiting for load data ----
    step();
    drive_instr(32'h1C00_0300, vecs[5]);
    step();
    me_valid = 1'b0;
    @(negedge clk);
    chk("rst_ld_pending", {fwd_pending, fwd_dest}, {1'b1, 5'd9});
    step();
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {rf_we, fwd_dest, fwd_pending, excp_flush, ertn_flush, wb_ecode}, 64'h0);
    chk("rst_mid_data", {fwd_data, wb_pc}, 64'h0);
    step();
    resetn = 1'b1;
    rdata_valid = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk);
    chk("late_rdata", {rf_we, fwd_pending, wb_allowin}, {1'b0, 1'b0, 1'b1});
    step();
    rdata_valid = 1'b0;
    @(negedge clk);
    chk("late_rdata_after", {rf_we, rf_wdata, fwd_pending}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
